// File: rtl/session_rr_arbiter.sv
// session_rr_arbiter: N-way round-robin arbiter with session hold.
//
// One requester is granted at a time. The grant is held until the grantee
// signals end of session, or until the watchdog forcibly releases it. After
// each release, priority rotates so that the released requester becomes the
// lowest priority.
//
// Ports:
//   clk                  rising-edge clock
//   rst_an               synchronous active-low reset
//   req[N]               level request per requester
//   session_is_finished  current grantee ends its session (used in BUSY only)
//   grant[N]             registered one-hot grant, or zero
//   grant_valid          registered, equals |grant
//   grant_idx[IW]        registered grantee index, 0 when idle
//   timeout              registered one-cycle pulse after a watchdog release
module session_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 255,
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_an,
  input  logic [N-1:0]  req,
  input  logic          session_is_finished,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic          timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [IW-1:0] rotate_ptr_q;
  logic [HW-1:0] hold_cnt_q;

  logic [IW-1:0] next_ptr;
  logic [IW-1:0] scan_ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
  logic [N-1:0]  win_onehot;
  logic          wd_hit;
  logic          release_ev;

  // Pointer after a release: one past the current holder, wrapping at N-1.
  assign next_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

  // In BUSY the scan only matters on a release, where it uses the rotated pointer.
  assign scan_ptr = (state_q == StBusy) ? next_ptr : rotate_ptr_q;

  assign wd_hit     = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD - 1));
  assign release_ev = session_is_finished || wd_hit;

  // Cyclic priority scan starting at scan_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(scan_ptr) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = {{(N - 1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_q      <= StIdle;
      rotate_ptr_q <= '0;
      hold_cnt_q   <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant       <= win_onehot;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            hold_cnt_q  <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
          if (release_ev) begin
            rotate_ptr_q <= next_ptr;
            // A simultaneous finish counts as a normal release.
            timeout      <= wd_hit && !session_is_finished;
            if (win_found) begin
              grant       <= win_onehot;
              grant_valid <= 1'b1;
              grant_idx   <= win_idx;
              hold_cnt_q  <= '0;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
              state_q     <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/session_rr_arbiter.md
# session_rr_arbiter

Parametrised round-robin arbiter with session hold, the N-way successor of the fixed 4-way session arbiter. It sits in front of a shared resource, such as a bus port or memory channel, and grants exactly one requester at a time. It holds that grant until the master signals end of session. If a watchdog expires first, it revokes the grant, so a hung master cannot starve the others. Priority rotates so that the most recently served requester becomes lowest priority.

## Interface
- N, 4: number of requesters, legal range 2..16; non-power-of-two values are legal.
- MAX_HOLD, 255: maximum number of cycles a grant may be held; 0 disables the watchdog; legal range 0..65535.
- IW, $clog2(N): derived localparam giving the index width.
- HW, $clog2(MAX_HOLD+1) (minimum 1): derived localparam giving the hold-counter width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_an  in  1  synchronous, active-low reset; it is sampled on the clk rising edge.
- req  in  N  level request per requester.
- session_is_finished  in  1  the current grantee ends its session; sampled only in BUSY.
- grant  out  N  registered one-hot grant, or all zero.
- grant_valid  out  1  registered; equals |grant.
- grant_idx  out  IW  registered index of the grantee; 0 when there is no grant.
- timeout  out  1  registered one-cycle pulse indicating a forced release by the watchdog.

## Operation
- Reset (rst_an=0 at an edge): the following take effect on that edge, including mid-session:
  - grant=0, grant_valid=0, grant_idx=0, timeout=0
  - rotate_ptr=0, hold_cnt=0, state=IDLE
- State machine, two states: IDLE and BUSY.
- Winner selection (combinational): the first index i with req[i]=1, scanning cyclically from rotate_ptr upward through N-1 and wrapping to 0.
- Behaviour in IDLE:
  - If req≠0, load the winner into grant/grant_idx, clear hold_cnt to 0, and go to BUSY.
  - Otherwise stay in IDLE with outputs at zero.
  - session_is_finished is ignored in IDLE.
- Behaviour in BUSY:
  - The grant is held regardless of req. A requester dropping req does not end its session.
  - hold_cnt increments by 1 each BUSY cycle and saturates at its maximum.
  - A release event occurs when session_is_finished=1, or when MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1.
- On a release event:
  - rotate_ptr is set to (grant_idx+1) mod N; an index of N-1 wraps to 0.
  - The winner is computed from the current req using the updated pointer.
  - If req≠0, the new winner is loaded, hold_cnt is cleared, and the state stays BUSY. This is a back-to-back handover with no idle cycle.
  - If req=0, grant is cleared and the state goes to IDLE.
- Re-grant of the same holder: if the releasing holder is the only requester, it is re-granted, and a new session starts with hold_cnt=0.
- Timeout pulse: timeout=1 for exactly the one cycle following a watchdog release.
  - If session_is_finished and the watchdog condition occur in the same cycle, the release is treated as normal and timeout stays 0.
- rotate_ptr changes only on release events.
- Grant on entry from IDLE: rotate_ptr is unchanged, so a newly granted requester is never skipped.

## Timing
- req to grant: 1 cycle. A req sampled at edge k in IDLE produces grant visible after edge k.
- Session release to next grant: 1 cycle. The new grant replaces the old one at the same edge that samples session_is_finished.
- Maximum hold: with the watchdog enabled, grant stays asserted for at most MAX_HOLD consecutive cycles per session.
- Registered outputs: grant, grant_valid, grant_idx and timeout all come from registers and have no combinational path from the inputs.
- Combinational depth: the N-wide cyclic priority scan feeds the registers only.

## Test plan
- Reset and idle: hold rst_an=0 for 2 cycles with req=4'b1111, then release. Required: all outputs are 0 during reset; grant=4'b0001 and grant_idx=0 one cycle after reset deasserts.
- Rotation (N=4, MAX_HOLD=0, req=4'b1111): pulse session_is_finished for one cycle every 3 cycles. Required: grant sequence 0001→0010→0100→1000→0001, handing over with no zero-grant cycle between sessions.
- Sticky session and re-grant: with grant=0010, drop req to 4'b0010 for 20 cycles. Required: grant stays 0010. Then pulse finish. Required: grant=0010 again and rotate_ptr=2. Then set req=4'b0101 and pulse finish. Required: grant=0100.
- Watchdog (MAX_HOLD=5, req=4'b0011, no finish): required grant 0001 for exactly 5 cycles, then 0010 with timeout=1 for one cycle. Finish and timeout in the same cycle: required timeout=0.
- Non-power-of-two wrap (N=3): holder idx 2 finishes with req=3'b111. Required: next grant=3'b001 and grant_idx never reaches 3. Finish with req=0: required IDLE and grant=0 on the next cycle.
- Reset mid-session: assert rst_an=0 while grant=0100. Required: grant=0 and rotate_ptr=0 after that edge. After reset is released with req=4'b1111, required grant=0001.
